sqrt_rr_scheduler: RTL

- Shares one combinational approximate square-root unit (16-bit radicand R, 8-bit root Q; any MAHSQR k-variant) between NUM_REQ requesters, e.g. parallel Sobel gradient-magnitude lanes.
- Requesters are arbitrated round-robin with a valid/ready handshake.
- Each radicand is registered into the sqrt unit and the root is captured, tagged with the requester ID, in a 2-stage pipeline with full backpressure.
- The sqrt unit sits outside this block, on the sqrt_r/sqrt_q ports, so that variants can be swapped.

---
 rtl/sqrt_rr_scheduler_pkg.sv | 13 +
 rtl/sqrt_rr_scheduler_if.sv | 23 ++
 rtl/sqrt_rr_scheduler_rr_arbiter.sv | 19 +
 rtl/sqrt_rr_scheduler.sv | 66 ++++++
 4 files changed

// File: rtl/sqrt_rr_scheduler_pkg.sv
// sqrt_sched_pkg: shared widths and the stage-1 payload for the round-robin sqrt scheduler
package sqrt_sched_pkg;
  localparam int R_W = 16;
  localparam int Q_W = 8;
  localparam int ID_MAX_W = 3;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  typedef struct packed {
    logic [R_W-1:0]      r;
    logic [ID_MAX_W-1:0] id;
  } stage_t;
endpackage

// File: rtl/sqrt_rr_scheduler_if.sv
// sqrt_rr_scheduler_if: requester-side and response-side handshakes of the scheduler
interface sqrt_rr_scheduler_if
  import sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = id_w(NUM_REQ);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*R_W-1:0] req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   resp_valid;
  logic [Q_W-1:0]         resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_ready;
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/sqrt_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, grant gated by en
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);
  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = ID_W'((int'(ptr) + k) % NUM_REQ);
    gnt = (en && |req) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler: round-robin sharing of one external sqrt unit through a
// 2-stage backpressured pipeline tagging each root with its requester id.
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sqrt_rr_scheduler_if.slave       bus,
  output logic [R_W-1:0]           sqrt_r,
  input  logic [Q_W-1:0]           sqrt_q,
  output logic                     busy
);
  localparam int ID_W = id_w(NUM_REQ);
  stage_t              s1_q, s1_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s2_valid_q, s2_valid_d;
  logic [Q_W-1:0]      s2_root_q, s2_root_d;
  logic [ID_MAX_W-1:0] s2_id_q, s2_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     idx;
  logic                stall, adv1, acc;
  assign stall = s2_valid_q & ~bus.resp_ready;
  assign adv1  = ~s1_valid_q | ~stall;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (adv1 & rst_n),
    .gnt (gnt),
    .idx (idx)
  );
  assign acc = |(bus.req_valid & gnt);
  always_comb begin
    s1_d       = acc ? '{r: bus.req_data[int'(idx)*R_W +: R_W], id: ID_MAX_W'(idx)} : s1_q;
    s1_valid_d = adv1 ? acc : s1_valid_q;
    ptr_d      = acc ? ((int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1) : ptr_q;
    s2_valid_d = stall ? s2_valid_q : s1_valid_q;
    s2_root_d  = stall ? s2_root_q : sqrt_q;
    s2_id_d    = stall ? s2_id_q : s1_q.id;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_root_q  <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_root_q  <= s2_root_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end
  assign bus.req_ready  = gnt;
  assign bus.resp_valid = s2_valid_q;
  assign bus.resp_data  = s2_root_q;
  assign bus.resp_id    = ID_W'(s2_id_q);
  assign sqrt_r         = s1_q.r;
  assign busy           = s1_valid_q | s2_valid_q;
endmodule
